// File: rtl/modrm_decoder.sv
// Sequential ModR/M decoder: pulls ModR/M and displacement bytes from the instruction FIFO,
// reads base/index registers and produces the 16-bit effective address.
module modrm_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clear,
    input  logic [7:0]  fifo_rd_data,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [2:0]  regfile_rd_sel0,
    output logic [2:0]  regfile_rd_sel1,
    input  logic [15:0] regfile_rd_val0,
    input  logic [15:0] regfile_rd_val1,
    output logic        busy,
    output logic        complete,
    output logic [1:0]  mod_field,
    output logic [2:0]  reg_field,
    output logic [2:0]  rm_field,
    output logic        rm_is_reg,
    output logic        uses_bp,
    output logic [15:0] effective_address
);

    typedef enum logic [2:0] {
        IDLE,
        MODRM,
        DISP_LO,
        DISP_HI,
        EA_WAIT,
        DONE
    } state_t;

    state_t      state, state_nx;
    logic [7:0]  modrm;
    logic        modrm_valid;
    logic [15:0] disp;
    logic [2:0]  base_sel, index_sel;
    logic        use0, use1;
    logic [15:0] ea_sum;

    assign mod_field = modrm[7:6];
    assign reg_field = modrm[5:3];
    assign rm_field  = modrm[2:0];
    assign rm_is_reg = (mod_field == 2'b11);
    assign uses_bp   = !rm_is_reg && ((rm_field == 3'b010) || (rm_field == 3'b011) ||
                                      ((rm_field == 3'b110) && (mod_field != 2'b00)));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        fifo_rd_en = 1'b0;
        if (clear) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nx = MODRM;
                MODRM:
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        case (fifo_rd_data[7:6])
                            2'b11:        state_nx = DONE;
                            2'b01, 2'b10: state_nx = DISP_LO;
                            default:      state_nx = (fifo_rd_data[2:0] == 3'b110) ? DISP_LO : EA_WAIT;
                        endcase
                    end
                DISP_LO:
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nx   = (mod_field == 2'b01) ? DONE : DISP_HI;
                    end
                DISP_HI:
                    if (!fifo_empty) begin
                        fifo_rd_en = 1'b1;
                        state_nx   = DONE;
                    end
                EA_WAIT: state_nx = DONE;
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        base_sel  = 3'd3;
        index_sel = 3'd0;
        case (rm_field)
            3'b000: begin base_sel = 3'd3; index_sel = 3'd6; end
            3'b001: begin base_sel = 3'd3; index_sel = 3'd7; end
            3'b010: begin base_sel = 3'd5; index_sel = 3'd6; end
            3'b011: begin base_sel = 3'd5; index_sel = 3'd7; end
            3'b100: base_sel = 3'd6;
            3'b101: base_sel = 3'd7;
            3'b110: base_sel = 3'd5;
            default: base_sel = 3'd3;
        endcase
        use0 = !((mod_field == 2'b00) && (rm_field == 3'b110));
        use1 = !rm_field[2];
    end

    // Selects stay zero until a ModR/M byte has actually been latched; register mode reads rm.
    always_comb begin
        regfile_rd_sel0 = '0;
        regfile_rd_sel1 = '0;
        if (modrm_valid) begin
            if (rm_is_reg) begin
                regfile_rd_sel0 = rm_field;
            end else begin
                regfile_rd_sel0 = use0 ? base_sel : 3'd0;
                regfile_rd_sel1 = use1 ? index_sel : 3'd0;
            end
        end
    end

    always_comb begin
        ea_sum = '0;
        if (!rm_is_reg)
            ea_sum = (use0 ? regfile_rd_val0 : 16'h0000) + (use1 ? regfile_rd_val1 : 16'h0000) + disp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            modrm             <= '0;
            modrm_valid       <= 1'b0;
            disp              <= '0;
            effective_address <= '0;
            complete          <= 1'b0;
        end else begin
            complete <= 1'b0;
            if (fifo_rd_en) begin
                case (state)
                    MODRM: begin
                        modrm       <= fifo_rd_data;
                        modrm_valid <= 1'b1;
                        disp        <= '0;
                    end
                    DISP_LO:
                        disp <= (mod_field == 2'b01) ? {{8{fifo_rd_data[7]}}, fifo_rd_data}
                                                     : {8'h00, fifo_rd_data};
                    DISP_HI: disp[15:8] <= fifo_rd_data;
                    default: ;
                endcase
            end
            if ((state == DONE) && !clear) begin
                effective_address <= ea_sum;
                complete          <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_modrm_decoder.sv
// Randomized scoreboard bench for modrm_decoder with a FIFO / register-file model and
// an address-mode reference model.
module tb_modrm_decoder;

    logic        clk = 1'b0;
    logic        reset, start, clear;
    logic [7:0]  fifo_rd_data;
    logic        fifo_empty, fifo_rd_en;
    logic [2:0]  sel0, sel1;
    logic [15:0] val0, val1;
    logic        busy, complete;
    logic [1:0]  mod_field;
    logic [2:0]  reg_field, rm_field;
    logic        rm_is_reg, uses_bp;
    logic [15:0] ea;

    modrm_decoder dut (
        .clk(clk), .reset(reset), .start(start), .clear(clear),
        .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .regfile_rd_sel0(sel0), .regfile_rd_sel1(sel1),
        .regfile_rd_val0(val0), .regfile_rd_val1(val1),
        .busy(busy), .complete(complete),
        .mod_field(mod_field), .reg_field(reg_field), .rm_field(rm_field),
        .rm_is_reg(rm_is_reg), .uses_bp(uses_bp), .effective_address(ea)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Register file: registered read, one cycle after select.
    logic [15:0] regs [0:7];
    always @(posedge clk) begin
        val0 <= regs[sel0];
        val1 <= regs[sel1];
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [7:0]  modrm;
        logic [15:0] ea;
        logic [2:0]  s0, s1;
        logic        chk_sel;
        logic        bp;
        int          lat;
        int          start_cnt;
    } exp_t;

    exp_t sb[$];
    exp_t me;

    // Monitor: every complete pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && complete) begin
            if (sb.size() == 0) begin
                chk("spurious_complete", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("mod_field", {30'd0, mod_field}, {30'd0, me.modrm[7:6]});
                chk("reg_field", {29'd0, reg_field}, {29'd0, me.modrm[5:3]});
                chk("rm_field", {29'd0, rm_field}, {29'd0, me.modrm[2:0]});
                chk("rm_is_reg", {31'd0, rm_is_reg}, {31'd0, (me.modrm[7:6] == 2'b11)});
                chk("uses_bp", {31'd0, uses_bp}, {31'd0, me.bp});
                chk("effective_address", {16'd0, ea}, {16'd0, me.ea});
                chk("busy_at_complete", {31'd0, busy}, 32'd0);
                chk("latency", cyc_cnt - me.start_cnt, me.lat);
                if (me.chk_sel) begin
                    chk("sel0", {29'd0, sel0}, {29'd0, me.s0});
                    chk("sel1", {29'd0, sel1}, {29'd0, me.s1});
                end
            end
        end
    end

    logic [7:0] fq[$];
    logic       stall;
    bit         pop_now;
    int         pops = 0;

    task automatic drive_fifo();
        fifo_empty   = stall || (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic cyc();
        @(negedge clk);
        pop_now = fifo_rd_en;
        @(posedge clk);
        #1;
        if (pop_now) begin
            pops++;
            chk("pop_while_empty", {31'd0, fifo_empty}, 32'd0);
            if (fq.size() != 0) void'(fq.pop_front());
        end
    endtask

    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [31:0] stalls);
        int base_t [8] = '{3, 3, 5, 5, 6, 7, 5, 3};
        int idx_t  [8] = '{6, 7, 6, 7, 0, 0, 0, 0};
        int md, rm, n, ewait, t, consumed, p0;
        bit direct, seen;
        int unsigned disp, sum;
        exp_t e;
        md     = int'(b0[7:6]);
        rm     = int'(b0[2:0]);
        direct = (md == 0) && (rm == 6);
        n      = (md == 3) ? 1 : (md == 1) ? 2 : (md == 2 || direct) ? 3 : 1;
        ewait  = (md == 0 && !direct) ? 1 : 0;
        if (md == 1)                disp = (b1 >= 8'h80) ? 32'hFF00 + b1 : b1;
        else if (md == 2 || direct) disp = b2 * 256 + b1;
        else                        disp = 0;
        if (md == 3)     sum = 0;
        else if (direct) sum = disp;
        else             sum = regs[base_t[rm]] + ((rm < 4) ? regs[idx_t[rm]] : 0) + disp;
        t = 1;
        consumed = 0;
        while (consumed < n) begin
            if (!stalls[t]) consumed++;
            t++;
        end
        e.modrm     = b0;
        e.ea        = 16'(sum % 65536);
        e.chk_sel   = (md != 3);
        e.s0        = direct ? 3'd0 : 3'(base_t[rm]);
        e.s1        = (rm < 4) ? 3'(idx_t[rm]) : 3'd0;
        e.bp        = (md != 3) && (rm == 2 || rm == 3 || (rm == 6 && md != 0));
        e.lat       = (t - 1) + ewait + 1;
        e.start_cnt = cyc_cnt + 1;
        fq.push_back(b0);
        if (n > 1) fq.push_back(b1);
        if (n > 2) fq.push_back(b2);
        sb.push_back(e);
        p0    = pops;
        start = 1'b1;
        stall = 1'b0;
        drive_fifo();
        seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            cyc();
            start = 1'b0;
            stall = (k < 32) ? stalls[k] : 1'b0;
            drive_fifo();
            if (complete) seen = 1'b1;
        end
        if (!seen) begin
            chk("complete_timeout", 32'd0, 32'd1);
            sb.delete();
        end
        stall = 1'b0;
        drive_fifo();
        chk("pop_count", pops - p0, n);
    endtask

    task automatic rand_regs();
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_complete"}, {31'd0, complete}, 32'd0);
        chk({tag, "_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        chk({tag, "_fields"}, {24'd0, mod_field, reg_field, rm_field}, 32'd0);
        chk({tag, "_sels"}, {26'd0, sel0, sel1}, 32'd0);
        chk({tag, "_ea"}, {16'd0, ea}, 32'd0);
        chk({tag, "_flags"}, {30'd0, rm_is_reg, uses_bp}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        stall = 1'b0;
        rand_regs();
        drive_fifo();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        cyc();

        // Directed cases
        run_txn(8'hC3, 8'h00, 8'h00, 32'd0);
        rand_regs(); regs[3] = 16'h1000; regs[6] = 16'h0234;
        run_txn(8'h00, 8'h00, 8'h00, 32'd0);
        rand_regs(); regs[5] = 16'h0100;
        run_txn(8'h46, 8'hF0, 8'h00, 32'd0);
        rand_regs();
        run_txn(8'h06, 8'h78, 8'h56, 32'd0);
        rand_regs(); regs[3] = 16'hFFFF; regs[7] = 16'h0002;
        run_txn(8'h81, 8'h01, 8'h00, 32'h0000_0038);

        // Random transactions, sometimes back-to-back
        for (int i = 0; i < 60; i++) begin
            rand_regs();
            run_txn(8'($urandom), 8'($urandom), 8'($urandom),
                    $urandom & $urandom & $urandom & 32'h0000_0FFE);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) cyc();
            end
        end

        // clear while in DISP_LO
        fq.push_back(8'h80); fq.push_back(8'h11); fq.push_back(8'h22);
        start = 1'b1;
        drive_fifo();
        cyc();
        start = 1'b0;
        cyc();
        clear = 1'b1;
        @(negedge clk);
        chk("clear_no_pop", {31'd0, fifo_rd_en}, 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("clear_idle", {31'd0, busy}, 32'd0);
        chk("clear_keeps_mod", {30'd0, mod_field}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            chk("clear_no_complete", {31'd0, complete}, 32'd0);
            cyc();
        end
        fq.delete();
        drive_fifo();

        // reset while in DISP_HI
        rand_regs();
        fq.push_back(8'h81); fq.push_back(8'h01); fq.push_back(8'h00);
        start = 1'b1;
        drive_fifo();
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        cyc();
        cyc();
        fq.delete();
        drive_fifo();
        reset = 1'b0;
        cyc();
        chk("after_reset_idle", {31'd0, busy}, 32'd0);

        // Recovery after reset
        rand_regs();
        run_txn(8'h52, 8'h80, 8'h00, 32'd0);
        repeat (3) cyc();
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modrm_decoder.md
# modrm_decoder

Sequential ModR/M decoder and effective-address unit for the 80x86 core. On `start` it pulls the ModR/M byte and any displacement bytes from the instruction-byte FIFO, decodes the fields, and reads base/index registers through the two read ports of the general-purpose register file. It then produces the 16-bit effective address for the microcode sequencer, which it feeds directly.

## Interface
No parameters.
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `start`  in  1  begin decode; sampled only in IDLE
- `clear`  in  1  synchronous flush to IDLE, no `complete`
- `fifo_rd_data`  in  8  head byte of show-ahead instruction FIFO, valid while `!fifo_empty`
- `fifo_empty`  in  1  FIFO has no bytes
- `fifo_rd_en`  out  1  pop head byte at this clock edge
- `regfile_rd_sel0`  out  3  register file read port 0 select (base / sole register)
- `regfile_rd_sel1`  out  3  register file read port 1 select (index)
- `regfile_rd_val0`  in  16  port 0 data, valid one cycle after select
- `regfile_rd_val1`  in  16  port 1 data, valid one cycle after select
- `busy`  out  1  not in IDLE
- `complete`  out  1  one-cycle pulse: decode results valid
- `mod_field`  out  2  ModR/M bits [7:6]
- `reg_field`  out  3  ModR/M bits [5:3]
- `rm_field`  out  3  ModR/M bits [2:0]
- `rm_is_reg`  out  1  `mod_field == 2'b11`
- `uses_bp`  out  1  BP used in address (default segment SS)
- `effective_address`  out  16  computed EA; 0 when `rm_is_reg`

## Operation
- States: IDLE, MODRM, DISP_LO, DISP_HI, EA_WAIT, DONE.
- IDLE: `start=1` -> MODRM. `start` is ignored in all other states.
- `fifo_rd_en = !fifo_empty` in MODRM, DISP_LO, and DISP_HI; otherwise 0. While the FIFO is empty the state is held.
- MODRM: on pop, latch the byte into the mod/reg/rm fields. Next state:
  - mod=11 -> DONE
  - mod=01 -> DISP_LO
  - mod=10 -> DISP_LO
  - mod=00, rm=110 -> DISP_LO
  - other mod=00 -> EA_WAIT
- DISP_LO: latch byte. If mod=01, disp = sign-extended byte and next state is DONE. Otherwise next state is DISP_HI.
- DISP_HI: latch high byte -> DONE.
- EA_WAIT: one cycle, guaranteeing the register file has registered the held selects -> DONE.
- DONE: compute `effective_address = (use0 ? val0 : 0) + (use1 ? val1 : 0) + disp`, modulo 2^16. Register it and pulse `complete`, then -> IDLE.
- Select and usage decode, as (sel0, sel1):
  - rm 000 -> (BX=3, SI=6)
  - rm 001 -> (BX, DI=7)
  - rm 010 -> (BP=5, SI)
  - rm 011 -> (BP, DI)
  - rm 100 -> (SI, —)
  - rm 101 -> (DI, —)
  - rm 110 -> (BP, —); with mod=00 there is no register, EA = disp16
  - rm 111 -> (BX, —)
  - Unused ports drive 0 and their value is masked.
- `uses_bp = !rm_is_reg && (rm==010 || rm==011 || (rm==110 && mod!=00))`.
- Selects are driven from the latched ModR/M register. They are stable from the cycle after MODRM pops until the next `start`.
- disp = 0 when no displacement bytes are present.
- `clear` has priority over all transitions: -> IDLE, no pop, no `complete`. Field outputs keep their previous values.
- The sequencer holds register-file `is_8_bit` low while `busy`.

## Timing
- Reset: state IDLE, and all of the following are 0: `busy`, `complete`, `fifo_rd_en`, fields, selects, `effective_address`, `uses_bp`, `rm_is_reg`, disp.
- Let `start` be sampled at edge E, with the FIFO never empty. `complete` is high in the cycle following:
  - edge E+2 for mod=11
  - edge E+3 for mod=00, no displacement
  - edge E+3 for mod=01
  - edge E+4 for mod=10
  - edge E+4 for mod=00 rm=110
- Each empty-FIFO cycle in a read state adds one cycle.
- `complete` is registered and lasts exactly one cycle, coincident with IDLE. Outputs stay stable until the next MODRM pop.
- `start` asserted in the same cycle as `complete` is accepted.
- `reset` mid-operation aborts immediately. No FIFO pop occurs on that edge.

## Test plan
- Register mode, byte 0xC3, FIFO full -> `rm_is_reg=1`, `reg_field=0`, `rm_field=3`, `effective_address=0`, `complete` after E+2, exactly one pop.
- Byte 0x00, BX=0x1000, SI=0x0234 -> sel0=3, sel1=6, `effective_address=0x1234`, `uses_bp=0`, `complete` after E+3.
- Bytes 0x46 0xF0 (mod=01, rm=110), BP=0x0100 -> `effective_address=0x00F0`, `uses_bp=1`, two pops.
- Bytes 0x06 0x78 0x56 (direct address) -> `effective_address=0x5678`, `uses_bp=0`, sel0=sel1=0, three pops.
- Bytes 0x81 0x01 0x00, BX=0xFFFF, DI=0x0002 -> `effective_address=0x0002` (wrap-around). Hold `fifo_empty=1` for 3 cycles before DISP_HI -> `complete` delayed by exactly 3 cycles, no pop while empty.
- Assert `clear` in DISP_LO -> IDLE next cycle, no `complete`, no pop that edge. Assert `reset` in DISP_HI -> all outputs 0 immediately.
